// File: rtl/pcie_host_mem_rsp.sv
// Host-memory responder for the RdRq/WrRq request channels: 128-bit word array,
// programmable response latency, address error checking. Optional `PCIE_RSP_ERR_INJ_EN adds ErrInj.
module pcie_host_mem_rsp #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned LAT_CYC   = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         RdRqValid,
    input  logic [63:0]  RdRqAddr,
    output logic [127:0] RdRqData,
    output logic         RdRqReady,
    output logic         RdRqErr,
    input  logic         WrRqValid,
    input  logic [63:0]  WrRqAddr,
    input  logic [127:0] WrRqData,
    output logic         WrRqReady,
    output logic         WrRqErr
`ifdef PCIE_RSP_ERR_INJ_EN
    ,
    input  logic         ErrInj
`endif
);

    localparam int unsigned       AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0]       MEM_BYTES = 64'(DEPTH) << 4;
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(LAT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_gnt_wr;
    logic               r_rr_last_wr;
    logic               r_addr_err;
    logic [AW-1:0]      r_idx;
    logic [127:0]       r_wdata;
    logic               r_rd_ready;
    logic               r_wr_ready;
    logic               r_rd_err;
    logic               r_wr_err;
    logic [127:0]       r_rdata;
    logic [127:0]       r_mem [DEPTH];

    logic               w_gnt_wr;
    logic [63:0]        w_req_addr;
    logic [64:0]        w_off;
    logic               w_addr_err;
    logic               w_inj;
    logic               w_resp_err;
    logic               w_mem_we;
    logic               w_can_grant;

    // Round-robin: with both channels requesting, serve the one not granted last
    assign w_gnt_wr   = WrRqValid & (~RdRqValid | ~r_rr_last_wr);
    assign w_req_addr = w_gnt_wr ? WrRqAddr : RdRqAddr;

    // 65-bit subtract so an address below BASE_ADDR shows up as a borrow
    assign w_off      = {1'b0, w_req_addr} - {1'b0, BASE_ADDR};
    assign w_addr_err = w_off[64] | (w_off[63:0] >= MEM_BYTES) | (w_req_addr[3:0] != 4'h0);

    // A Ready is on the wire this cycle: hold off so a still-high Valid is not re-captured
    assign w_can_grant = ~r_rd_ready & ~r_wr_ready & (RdRqValid | WrRqValid);

`ifdef PCIE_RSP_ERR_INJ_EN
    logic r_inj;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inj <= 1'b0;
        end else if (ErrInj) begin
            r_inj <= 1'b1;
        end else if (r_state == S_RESP) begin
            r_inj <= 1'b0;
        end
    end

    assign w_inj = r_inj;
`else
    assign w_inj = 1'b0;
`endif

    assign w_resp_err = r_addr_err | w_inj;
    assign w_mem_we   = rst_n & (r_state == S_RESP) & r_gnt_wr & ~w_resp_err;

    // Control FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_gnt_wr     <= 1'b0;
            r_rr_last_wr <= 1'b1;
            r_addr_err   <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_rd_ready   <= 1'b0;
            r_wr_ready   <= 1'b0;
            r_rd_err     <= 1'b0;
            r_wr_err     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_rd_ready <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_err   <= 1'b0;
            r_wr_err   <= 1'b0;
            r_rdata    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_can_grant) begin
                        r_gnt_wr     <= w_gnt_wr;
                        r_rr_last_wr <= w_gnt_wr;
                        r_addr_err   <= w_addr_err;
                        r_idx        <= w_off[AW+3:4];
                        r_wdata      <= WrRqData;
                        r_cnt        <= CNT_INIT;
                        r_state      <= (CNT_INIT == '0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (r_gnt_wr) begin
                        r_wr_ready <= 1'b1;
                        r_wr_err   <= w_resp_err;
                    end else begin
                        r_rd_ready <= 1'b1;
                        r_rd_err   <= w_resp_err;
                        if (!w_resp_err) begin
                            r_rdata <= r_mem[r_idx];
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Word array is not reset; writes land only in the response cycle
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign RdRqData  = r_rdata;
    assign RdRqReady = r_rd_ready;
    assign RdRqErr   = r_rd_err;
    assign WrRqReady = r_wr_ready;
    assign WrRqErr   = r_wr_err;

endmodule
